// File: rtl/mem_axi_arbiter.sv
// Two-master to one-slave AXI burst arbiter (icache = master 0, dcache = master 1).
// Read and write channels arbitrate independently; grants last a whole burst.
module mem_axi_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int WAIT_BRESP = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          m_arvalid,
    input  logic [2*ADDR_W-1:0] m_araddr,
    input  logic [15:0]         m_arlen,
    input  logic [5:0]          m_arsize,
    input  logic [3:0]          m_arburst,
    output logic [1:0]          m_arready,
    output logic [1:0]          m_rvalid,
    output logic [1:0]          m_rlast,
    input  logic [1:0]          m_rready,
    output logic [DATA_W-1:0]   m_rdata,
    output logic [1:0]          m_rresp,
    input  logic [1:0]          m_awvalid,
    input  logic [2*ADDR_W-1:0] m_awaddr,
    input  logic [15:0]         m_awlen,
    input  logic [3:0]          m_awburst,
    output logic [1:0]          m_awready,
    input  logic [1:0]          m_wvalid,
    input  logic [2*DATA_W-1:0] m_wdata,
    input  logic [15:0]         m_wstrb,
    input  logic [1:0]          m_wlast,
    output logic [1:0]          m_wready,
    output logic [1:0]          m_bvalid,
    output logic [1:0]          m_bresp,
    input  logic [1:0]          m_bready,
    output logic                s_arvalid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [7:0]          s_arlen,
    output logic [2:0]          s_arsize,
    output logic [1:0]          s_arburst,
    input  logic                s_arready,
    input  logic                s_rvalid,
    input  logic                s_rlast,
    output logic                s_rready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    output logic                s_awvalid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [7:0]          s_awlen,
    output logic [1:0]          s_awburst,
    input  logic                s_awready,
    output logic                s_wvalid,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [7:0]          s_wstrb,
    output logic                s_wlast,
    input  logic                s_wready,
    input  logic                s_bvalid,
    input  logic [1:0]          s_bresp,
    output logic                s_bready,
    output logic                err_len
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;

    rstate_t     rstate, rstate_nxt;
    wstate_t     wstate, wstate_nxt;
    logic        rgnt, last_rgnt, wgnt, last_wgnt;
    logic [7:0]  rlen;
    logic [8:0]  beats;
    logic        ar_hs, r_hs, w_done;

    assign s_araddr  = rgnt ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];
    assign s_arlen   = rgnt ? m_arlen[15:8]   : m_arlen[7:0];
    assign s_arsize  = rgnt ? m_arsize[5:3]   : m_arsize[2:0];
    assign s_arburst = rgnt ? m_arburst[3:2]  : m_arburst[1:0];
    assign s_awaddr  = wgnt ? m_awaddr[2*ADDR_W-1:ADDR_W] : m_awaddr[ADDR_W-1:0];
    assign s_awlen   = wgnt ? m_awlen[15:8]   : m_awlen[7:0];
    assign s_awburst = wgnt ? m_awburst[3:2]  : m_awburst[1:0];
    assign s_wdata   = wgnt ? m_wdata[2*DATA_W-1:DATA_W] : m_wdata[DATA_W-1:0];
    assign s_wstrb   = wgnt ? m_wstrb[15:8]   : m_wstrb[7:0];
    assign s_wlast   = wgnt ? m_wlast[1]      : m_wlast[0];
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_bresp   = s_bresp;

    assign ar_hs = s_arvalid && s_arready;
    assign r_hs  = s_rvalid && s_rready;

    always_comb begin
        rstate_nxt = rstate;
        m_arready  = '0;
        m_rvalid   = '0;
        m_rlast    = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        unique case (rstate)
            R_IDLE: if (|m_arvalid) rstate_nxt = R_ADDR;
            R_ADDR: begin
                s_arvalid       = m_arvalid[rgnt];
                m_arready[rgnt] = s_arready;
                if (s_arvalid && s_arready) rstate_nxt = R_DATA;
            end
            R_DATA: begin
                m_rvalid[rgnt] = s_rvalid;
                m_rlast[rgnt]  = s_rlast;
                s_rready       = m_rready[rgnt];
                if (s_rvalid && s_rready && s_rlast) rstate_nxt = R_IDLE;
            end
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rstate    <= R_IDLE;
            rgnt      <= 1'b0;
            last_rgnt <= 1'b1;
            rlen      <= '0;
            beats     <= '0;
            err_len   <= 1'b0;
        end else begin
            rstate <= rstate_nxt;
            if (rstate == R_IDLE && |m_arvalid)
                rgnt <= (&m_arvalid) ? ~last_rgnt : m_arvalid[1];
            if (ar_hs) begin
                rlen  <= s_arlen;
                beats <= '0;
            end
            if (r_hs) begin
                beats <= beats + 9'd1;
                if (s_rlast) begin
                    if (beats + 9'd1 != {1'b0, rlen} + 9'd1) err_len <= 1'b1;
                    last_rgnt <= rgnt;
                end
            end
        end
    end

    // Without WAIT_BRESP the arbiter sinks every B itself.
    always_comb begin
        wstate_nxt = wstate;
        m_awready  = '0;
        m_wready   = '0;
        m_bvalid   = '0;
        s_awvalid  = 1'b0;
        s_wvalid   = 1'b0;
        s_bready   = (WAIT_BRESP == 0);
        w_done     = 1'b0;
        unique case (wstate)
            W_IDLE: if (|m_awvalid) wstate_nxt = W_ADDR;
            W_ADDR: begin
                s_awvalid       = m_awvalid[wgnt];
                m_awready[wgnt] = s_awready;
                if (s_awvalid && s_awready) wstate_nxt = W_DATA;
            end
            W_DATA: begin
                s_wvalid       = m_wvalid[wgnt];
                m_wready[wgnt] = s_wready;
                if (s_wvalid && s_wready && s_wlast) begin
                    wstate_nxt = (WAIT_BRESP != 0) ? W_RESP : W_IDLE;
                    w_done     = (WAIT_BRESP == 0);
                end
            end
            W_RESP: begin
                m_bvalid[wgnt] = s_bvalid;
                s_bready       = m_bready[wgnt];
                if (s_bvalid && s_bready) begin
                    wstate_nxt = W_IDLE;
                    w_done     = 1'b1;
                end
            end
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wstate    <= W_IDLE;
            wgnt      <= 1'b0;
            last_wgnt <= 1'b1;
        end else begin
            wstate <= wstate_nxt;
            if (wstate == W_IDLE && |m_awvalid)
                wgnt <= (&m_awvalid) ? ~last_wgnt : m_awvalid[1];
            if (w_done) last_wgnt <= wgnt;
        end
    end

endmodule

// File: tb/tb_mem_axi_arbiter.sv
// Bench for mem_axi_arbiter: two instances (WAIT_BRESP 1 and 0) on shared stimulus,
// checked each cycle against a transaction-level arbitration model plus directed literals.
module tb_mem_axi_arbiter;
    localparam int AW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0] m_arvalid, m_rready, m_awvalid, m_wvalid, m_wlast, m_bready;
    logic [2*AW-1:0] m_araddr, m_awaddr;
    logic [15:0] m_arlen, m_awlen, m_wstrb;
    logic [5:0] m_arsize;
    logic [3:0] m_arburst, m_awburst;
    logic [2*DW-1:0] m_wdata;
    logic s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid;
    logic [DW-1:0] s_rdata;
    logic [1:0] s_rresp, s_bresp;

    logic [1:0] m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid, m_rresp, m_bresp;
    logic [DW-1:0] m_rdata, s_wdata;
    logic s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast, s_bready, err_len;
    logic [AW-1:0] s_araddr, s_awaddr;
    logic [7:0] s_arlen, s_awlen, s_wstrb;
    logic [2:0] s_arsize;
    logic [1:0] s_arburst, s_awburst;

    logic [1:0] z_m_arready, z_m_rvalid, z_m_rlast, z_m_awready, z_m_wready, z_m_bvalid;
    logic [1:0] z_m_rresp, z_m_bresp;
    logic [DW-1:0] z_m_rdata, z_s_wdata;
    logic z_s_arvalid, z_s_rready, z_s_awvalid, z_s_wvalid, z_s_wlast, z_s_bready, z_err_len;
    logic [AW-1:0] z_s_araddr, z_s_awaddr;
    logic [7:0] z_s_arlen, z_s_awlen, z_s_wstrb;
    logic [2:0] z_s_arsize;
    logic [1:0] z_s_arburst, z_s_awburst;

    mem_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_BRESP(1)) u1 (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awburst(m_awburst), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arlen(s_arlen),
        .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(s_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awburst(s_awburst), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_wlast(s_wlast), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .err_len(err_len)
    );

    mem_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_BRESP(0)) u0 (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arready(z_m_arready),
        .m_rvalid(z_m_rvalid), .m_rlast(z_m_rlast), .m_rready(m_rready),
        .m_rdata(z_m_rdata), .m_rresp(z_m_rresp),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awburst(m_awburst), .m_awready(z_m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_wlast(m_wlast), .m_wready(z_m_wready),
        .m_bvalid(z_m_bvalid), .m_bresp(z_m_bresp), .m_bready(m_bready),
        .s_arvalid(z_s_arvalid), .s_araddr(z_s_araddr), .s_arlen(z_s_arlen),
        .s_arsize(z_s_arsize), .s_arburst(z_s_arburst), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rlast(s_rlast), .s_rready(z_s_rready),
        .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(z_s_awvalid), .s_awaddr(z_s_awaddr), .s_awlen(z_s_awlen),
        .s_awburst(z_s_awburst), .s_awready(s_awready),
        .s_wvalid(z_s_wvalid), .s_wdata(z_s_wdata), .s_wstrb(z_s_wstrb),
        .s_wlast(z_s_wlast), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(z_s_bready),
        .err_len(z_err_len)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    // Model: who owns each channel and which phase of the burst it is in.
    int ro = -1, rph = 0, rptr = 1, rcnt = 0, rexp = 0;
    bit rerr = 1'b0;
    int wo[2] = '{-1, -1};
    int wph[2] = '{0, 0};
    int wptr[2] = '{1, 1};

    function automatic int pick(input logic [1:0] req, input int ptr);
        if (req == 2'b11) return 1 - ptr;
        return req[1] ? 1 : 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ro = -1; rph = 0; rptr = 1; rcnt = 0; rerr = 1'b0;
            for (int k = 0; k < 2; k++) begin
                wo[k] = -1; wph[k] = 0; wptr[k] = 1;
            end
        end else begin
            if (ro < 0) begin
                if (m_arvalid != 2'b00) begin
                    ro = pick(m_arvalid, rptr); rph = 1;
                end
            end else if (rph == 1) begin
                if (m_arvalid[ro] && s_arready) begin
                    rph = 2; rcnt = 0; rexp = int'(m_arlen[ro*8+:8]) + 1;
                end
            end else if (s_rvalid && m_rready[ro]) begin
                rcnt++;
                if (s_rlast) begin
                    if (rcnt != rexp) rerr = 1'b1;
                    rptr = ro; ro = -1; rph = 0;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (wo[k] < 0) begin
                    if (m_awvalid != 2'b00) begin
                        wo[k] = pick(m_awvalid, wptr[k]); wph[k] = 1;
                    end
                end else if (wph[k] == 1) begin
                    if (m_awvalid[wo[k]] && s_awready) wph[k] = 2;
                end else if (wph[k] == 2) begin
                    if (m_wvalid[wo[k]] && s_wready && m_wlast[wo[k]]) begin
                        if (k == 1) wph[k] = 3;
                        else begin
                            wptr[k] = wo[k]; wo[k] = -1; wph[k] = 0;
                        end
                    end
                end else if (s_bvalid && m_bready[wo[k]]) begin
                    wptr[k] = wo[k]; wo[k] = -1; wph[k] = 0;
                end
            end
        end
    end

    task automatic cmp_w(input int k, input logic [1:0] awr, wr, bv,
                         input logic saw, sw, sb,
                         input logic [AW-1:0] sawa, input logic [DW-1:0] swd);
        int o = wo[k];
        int p = wph[k];
        logic [1:0] eaw = '0, ew = '0, eb = '0;
        logic esaw = 1'b0, esw = 1'b0, esb;
        esb = (k == 0);
        if (o >= 0 && p == 1) begin
            esaw = m_awvalid[o]; eaw[o] = s_awready;
            chk($sformatf("w%0d_s_awaddr", k), sawa, m_awaddr[o*AW+:AW]);
        end
        if (o >= 0 && p == 2) begin
            esw = m_wvalid[o]; ew[o] = s_wready;
            chk($sformatf("w%0d_s_wdata", k), swd, m_wdata[o*DW+:DW]);
        end
        if (o >= 0 && p == 3) begin
            eb[o] = s_bvalid; esb = m_bready[o];
        end
        chk($sformatf("w%0d_m_awready", k), awr, eaw);
        chk($sformatf("w%0d_m_wready", k), wr, ew);
        chk($sformatf("w%0d_m_bvalid", k), bv, eb);
        chk($sformatf("w%0d_s_awvalid", k), saw, esaw);
        chk($sformatf("w%0d_s_wvalid", k), sw, esw);
        chk($sformatf("w%0d_s_bready", k), sb, esb);
    endtask

    always @(negedge clk) begin
        logic [1:0] ear, erv, erl;
        logic esar, esrr;
        if (!rst) begin
            ear = '0; erv = '0; erl = '0; esar = 1'b0; esrr = 1'b0;
            if (ro >= 0 && rph == 1) begin
                esar = m_arvalid[ro]; ear[ro] = s_arready;
                chk("s_araddr", s_araddr, m_araddr[ro*AW+:AW]);
                chk("s_arlen", s_arlen, m_arlen[ro*8+:8]);
            end
            if (ro >= 0 && rph == 2) begin
                erv[ro] = s_rvalid; erl[ro] = s_rlast; esrr = m_rready[ro];
            end
            chk("m_arready", m_arready, ear);
            chk("s_arvalid", s_arvalid, esar);
            chk("m_rvalid", m_rvalid, erv);
            chk("m_rlast", m_rlast, erl);
            chk("s_rready", s_rready, esrr);
            chk("err_len", err_len, rerr);
            chk("m_rdata", m_rdata, s_rdata);
            cmp_w(1, m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready,
                  s_awaddr, s_wdata);
            cmp_w(0, z_m_awready, z_m_wready, z_m_bvalid, z_s_awvalid, z_s_wvalid,
                  z_s_bready, z_s_awaddr, z_s_wdata);
        end
    end

    int rv0 = 0, rv1 = 0;
    logic gq[$];
    always @(posedge clk) begin
        if (!rst) begin
            if (m_rvalid[0] && m_rready[0]) rv0++;
            if (m_rvalid[1]) rv1++;
            if (s_arvalid && s_arready) gq.push_back(m_arready[1]);
        end
    end

    task automatic do_reset(input logic [1:0] arv);
        rst = 1'b1;
        m_arvalid = arv; m_rready = 2'b11;
        m_awvalid = 2'b00; m_wvalid = 2'b00; m_wlast = 2'b00; m_bready = 2'b00;
        m_araddr = {32'h4000_0000, 32'h8000_0000};
        m_awaddr = {32'h5000_0100, 32'h9000_0200};
        m_arlen = {8'd7, 8'd7}; m_awlen = {8'd7, 8'd7};
        m_arsize = {3'd3, 3'd3}; m_arburst = 4'b0101; m_awburst = 4'b0101;
        m_wdata = '0; m_wstrb = 16'hFFFF;
        s_arready = 1'b1; s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
        s_rresp = 2'b00; s_awready = 1'b1; s_wready = 1'b1;
        s_bvalid = 1'b0; s_bresp = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_hi(input int which, input string nm);
        bit seen = 1'b0;
        #1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if ((which == 0 && s_arvalid) || (which == 1 && s_awvalid)) seen = 1'b1;
            else @(negedge clk);
        end
        chk(nm, seen, 1'b1);
    endtask

    task automatic rd_burst(input int nbeats, input bit hold);
        wait_hi(0, "ar_wait");
        @(posedge clk); #1;
        if (!hold) m_arvalid = 2'b00;
        s_rvalid = 1'b1;
        for (int b = 1; b <= nbeats; b++) begin
            s_rlast = (b == nbeats);
            s_rdata = 64'hD000 + 64'(b);
            @(negedge clk);
            chk("no_ar_in_data", s_arvalid, 1'b0);
            @(posedge clk); #1;
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, n1;
        do_reset(2'b00);
        rst = 1'b1;
        #1;
        chk("rst0_outs", {m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid,
             s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}, 16'h0);
        chk("rst0_err", err_len, 1'b0);
        chk("rst0_nowait_bready", z_s_bready, 1'b1);

        // single read from master 0
        do_reset(2'b00);
        n0 = rv0; n1 = rv1;
        m_arvalid = 2'b01;
        @(negedge clk); chk("t1_ar_lat0", s_arvalid, 1'b0);
        @(negedge clk); chk("t1_ar_lat1", s_arvalid, 1'b1);
        chk("t1_araddr", s_araddr, 32'h8000_0000);
        rd_burst(8, 1'b0);
        @(negedge clk);
        chk("t1_beats0", rv0 - n0, 8);
        chk("t1_beats1", rv1 - n1, 0);
        chk("t1_err", err_len, 1'b0);
        chk("t1_rready_idle", s_rready, 1'b0);
        chk("t1_model_rexp", rexp, 8);

        // both masters request continuously from reset
        do_reset(2'b11);
        m_arlen = {8'd3, 8'd3};
        n0 = gq.size();
        rd_burst(4, 1'b1);
        rd_burst(4, 1'b1);
        rd_burst(4, 1'b1);
        m_arvalid = 2'b00;
        chk("t2_ngrants", gq.size() - n0, 3);
        if (gq.size() >= n0 + 3) begin
            chk("t2_grant0", gq[n0], 1'b0);
            chk("t2_grant1", gq[n0+1], 1'b1);
            chk("t2_grant2", gq[n0+2], 1'b0);
        end

        // short burst: rlast on beat 6 of 8
        do_reset(2'b00);
        m_arvalid = 2'b01;
        rd_burst(6, 1'b0);
        chk("t3_err_set", err_len, 1'b1);
        chk("t3_model_rerr", rerr, 1'b1);
        n0 = rv0;
        m_arvalid = 2'b01;
        rd_burst(8, 1'b0);
        @(negedge clk);
        chk("t3_err_sticky", err_len, 1'b1);
        chk("t3_next_beats", rv0 - n0, 8);

        // async reset in the middle of a read burst
        m_arvalid = 2'b01;
        wait_hi(0, "t5_ar_wait");
        @(posedge clk); #1;
        m_arvalid = 2'b00;
        s_rvalid = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("t5_pre_rvalid", m_rvalid, 2'b01);
        chk("t5_pre_err", err_len, 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_rst_outs", {m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid,
             s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}, 16'h0);
        chk("t5_rst_err", err_len, 1'b0);
        do_reset(2'b11);
        wait_hi(0, "t5_tie_wait");
        chk("t5_tie_arready", m_arready, 2'b01);
        chk("t5_tie_addr", s_araddr, 32'h8000_0000);
        rd_burst(8, 1'b0);
        chk("t5_err_after", err_len, 1'b0);

        // write burst from master 1 on both variants
        do_reset(2'b00);
        m_awlen = {8'd7, 8'd0};
        m_awvalid = 2'b10;
        m_wvalid = 2'b10;
        m_wdata[2*DW-1:DW] = 64'hA0;
        @(negedge clk);
        chk("t4_aw_lat", s_awvalid, 1'b0);
        chk("t4_w_hold0", m_wready, 2'b00);
        wait_hi(1, "t4_aw_wait");
        chk("t4_w_hold1", m_wready, 2'b00);
        chk("t4_awaddr", s_awaddr, 32'h5000_0100);
        @(posedge clk); #1;
        m_awvalid = 2'b00;
        for (int b = 1; b <= 8; b++) begin
            m_wdata[2*DW-1:DW] = 64'hA0 + 64'(b);
            m_wlast = (b == 8) ? 2'b10 : 2'b00;
            @(negedge clk);
            chk("t4_wready", m_wready, 2'b10);
            chk("t4_wdata", s_wdata, 64'hA0 + 64'(b));
            @(posedge clk); #1;
        end
        m_wvalid = 2'b00; m_wlast = 2'b00;
        s_bvalid = 1'b1; s_awready = 1'b0; m_awvalid = 2'b01;
        @(negedge clk);
        chk("t4_bvalid", m_bvalid, 2'b10);
        chk("t4_bready_held", s_bready, 1'b0);
        chk("t4_nw_bvalid", z_m_bvalid, 2'b00);
        chk("t4_nw_bready", z_s_bready, 1'b1);
        chk("t4_nw_aw_lat", z_s_awvalid, 1'b0);
        @(negedge clk);
        chk("t4_nw_aw2", z_s_awvalid, 1'b1);
        chk("t4_w_grant_held", s_awvalid, 1'b0);
        chk("t4_bvalid2", m_bvalid, 2'b10);
        @(posedge clk); #1;
        m_bready = 2'b10;
        @(negedge clk);
        chk("t4_bready_hs", s_bready, 1'b1);
        @(posedge clk); #1;
        s_bvalid = 1'b0; m_bready = 2'b00;
        @(negedge clk);
        chk("t4_b_done", m_bvalid, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
